// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : encoder_pkg
//  Purpose  : Shared types and helpers for the encoder/serializer family.
//             - enc_state_t : serializer control states (IDLE, SCAN)
//             - popcount    : set-bit count over the low 'width' bits of a
//                             vector of up to c_popcnt_max_w bits
//  Revision : 1.0 - initial release
// ============================================================================
package encoder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } enc_state_t;

    // Widest request vector the popcount helper can handle. Callers
    // zero-extend their vector to this width and pass the real width.
    localparam int c_popcnt_max_w = 256;

    function automatic int unsigned popcount(
        input logic [c_popcnt_max_w-1:0] vec,
        input int unsigned               width
    );
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < c_popcnt_max_w; i++) begin
            if ((i < width) && vec[i]) begin
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

endpackage : encoder_pkg
`default_nettype wire

// File: rtl/prio_index.sv
`default_nettype none
// ============================================================================
//  Module   : prio_index
//  Purpose  : Combinational first-set-bit finder.
//             MSB_FIRST=0 reports the lowest set index, MSB_FIRST=1 the
//             highest. A first-match scan is used so that several set bits
//             produce the priority index rather than an OR of indices.
//  Ports    : vec   [N-1:0]     input  candidate bits
//             idx   [IDX_W-1:0] output priority index (0 when none set)
//             found             output at least one bit of vec is set
//  Revision : 1.0 - initial release
// ============================================================================
module prio_index #(
    parameter  int N         = 16,
    parameter  bit MSB_FIRST = 1'b0,
    localparam int IDX_W     = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan position i maps to bit i (LSB first) or bit N-1-i (MSB first).
    function automatic int scan_pos(input int i);
        return (MSB_FIRST != 1'b0) ? (N - 1 - i) : i;
    endfunction

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && vec[scan_pos(i)]) begin
                idx   = IDX_W'(scan_pos(i));
                found = 1'b1;
            end
        end
    end

endmodule : prio_index
`default_nettype wire

// File: rtl/encoder_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : encoder_serializer
//  Purpose  : Accepts an N-bit request vector over valid/ready and emits the
//             index of every set bit, one per output beat, in priority order.
//             The final index of each vector is flagged with out_last. An
//             all-zero vector is accepted, dropped and reported on 'empty'.
//  Ports    : clk, rst_n          clock, asynchronous active-low reset
//             enable              global enable (pauses accept and emission)
//             in_valid/in_ready   input handshake, in_vec [N-1:0]
//             out_valid/out_ready output handshake
//             out_idx [IDX_W-1:0] current priority index
//             out_last            out_idx is the last set bit of the vector
//             empty               one-cycle pulse for a dropped zero vector
//             pending_cnt [IDX_W:0] set bits not yet emitted
//  Revision : 1.0 - initial release
// ============================================================================
module encoder_serializer
    import encoder_pkg::*;
#(
    parameter  int N         = 16,
    parameter  bit MSB_FIRST = 1'b0,
    localparam int IDX_W     = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             empty,
    output logic [IDX_W:0]   pending_cnt
);

    // One extra bit so an all-ones vector's count of N fits.
    localparam int c_pend_w = IDX_W + 1;

    enc_state_t            r_state;
    logic [N-1:0]          r_rem;
    logic [c_pend_w-1:0]   r_pend;
    logic                  r_empty;

    enc_state_t            w_state_nxt;
    logic [N-1:0]          w_rem_nxt;
    logic [c_pend_w-1:0]   w_pend_nxt;
    logic                  w_empty_nxt;

    logic [IDX_W-1:0]      w_idx;
    logic                  w_found;
    logic [N-1:0]          w_clr_mask;
    logic [c_pend_w-1:0]   w_in_pop;
    logic                  w_is_last;

    prio_index #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio_index (
        .vec   (r_rem),
        .idx   (w_idx),
        .found (w_found)
    );

    assign w_in_pop  = c_pend_w'(popcount(c_popcnt_max_w'(in_vec), N));
    assign w_is_last = (r_pend == c_pend_w'(1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_pend  <= '0;
            r_empty <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_pend  <= w_pend_nxt;
            r_empty <= w_empty_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_pend_nxt  = r_pend;
        w_empty_nxt = 1'b0;
        w_clr_mask  = '0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_idx     = '0;
        out_last    = 1'b0;

        case (r_state)
            IDLE: begin
                // rst_n is folded in so in_ready is low for the whole time
                // reset is held, not only after the first clock edge.
                in_ready = enable && rst_n;
                if (in_valid && in_ready) begin
                    if (|in_vec) begin
                        w_rem_nxt   = in_vec;
                        w_pend_nxt  = w_in_pop;
                        w_state_nxt = SCAN;
                    end else begin
                        w_empty_nxt = 1'b1;
                    end
                end
            end

            SCAN: begin
                // With enable low everything is held: no valid, no clearing.
                out_valid = enable && w_found;
                out_idx   = w_idx;
                out_last  = w_is_last;
                if (out_valid && out_ready) begin
                    w_clr_mask[w_idx] = 1'b1;
                    w_rem_nxt         = r_rem & ~w_clr_mask;
                    w_pend_nxt        = r_pend - c_pend_w'(1);
                    if (w_is_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign empty       = r_empty;
    assign pending_cnt = r_pend;

endmodule : encoder_serializer
`default_nettype wire
